// File: rtl/mux_tree_pkg.sv
// Package: mux_tree_pkg
// Shared constants and elaboration-time helpers for the pipelined mux tree.
//   clog2(n)              ceiling log2, used to size the select and the number of levels
//   width(num_in, dw, k)  bit width of the words registered by level k
//   MUX_TREE_MAX_IN       largest supported channel count
package mux_tree_pkg;

    localparam int MUX_TREE_MAX_IN = 256;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Level k halves the word count of its input: NUM_IN >> (k+1) words of DATA_W bits.
    function automatic int width(input int num_in, input int data_w, input int k);
        return (num_in >> (k + 1)) * data_w;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// Module: mux_tree_stage
// One level of the mux tree: a bank of 2:1 muxes steered by select bit LEVEL,
// followed by an elastic register slice (data, full select tag, valid).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     upstream word/select valid
//   in_ready     this stage can load (empty, or its content leaves this cycle)
//   in_data      IN_WORDS words of DATA_W bits
//   in_sel       full select index travelling with the sample
//   out_valid    registered valid
//   out_ready    downstream accepts this cycle
//   out_data     IN_WORDS/2 registered words
//   out_sel      registered select index
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int IN_WORDS = 2,
    parameter int DATA_W   = 1,
    parameter int SEL_W    = 1,
    parameter int LEVEL    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [IN_WORDS*DATA_W-1:0]           in_data,
    input  logic [SEL_W-1:0]                     in_sel,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [width(IN_WORDS, DATA_W, 0)-1:0] out_data,
    output logic [SEL_W-1:0]                     out_sel
);

    localparam int OUT_WORDS = IN_WORDS / 2;
    localparam int OUT_W     = width(IN_WORDS, DATA_W, 0);

    logic [OUT_W-1:0] mux_d;
    logic             load;

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves
        // mux_d unassigned, which would infer a latch.
        mux_d = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            mux_d[j*DATA_W +: DATA_W] = in_sel[LEVEL] ? in_data[(2*j+1)*DATA_W +: DATA_W]
                                                      : in_data[(2*j)*DATA_W +: DATA_W];
        end
    end

    // Elastic slice: accept when empty or when the held word is leaving now.
    assign in_ready = !out_valid || out_ready;
    assign load     = in_ready && in_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
        end
    end

    // NOTE: the payload registers are reset as well, so out_data/out_sel read 0
    // after reset instead of stale values; they load only on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (load) begin
            out_data <= mux_d;
            out_sel  <= in_sel;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Module: mux_tree_pipe
// NUM_IN:1 selector built as SEL_W pipelined 2:1 mux levels with a ready/valid
// handshake; select and data travel together, one sample per clock.
// Build option: MUX_TREE_SCAN_EN adds the scan_en port and an internal scan
// counter that replaces sel while scan_en = 1.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     in_data/sel valid this cycle
//   in_ready     stage 0 can accept
//   in_data      channel i at bits [i*DATA_W +: DATA_W]
//   sel          channel index for this sample
//   out_valid    out_data/out_sel valid
//   out_ready    downstream accepts
//   out_data     selected channel data
//   out_sel      select index that produced out_data
//   scan_en      (MUX_TREE_SCAN_EN only) use the scan counter instead of sel
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter  int NUM_IN = 16,
    parameter  int DATA_W = 1,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel
`ifdef MUX_TREE_SCAN_EN
    ,
    input  logic                     scan_en
`endif
);

    if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
        $error("mux_tree_pipe: NUM_IN must be a power of two >= 2");
    end
    if (NUM_IN > MUX_TREE_MAX_IN) begin : g_too_wide
        $error("mux_tree_pipe: NUM_IN exceeds MUX_TREE_MAX_IN");
    end

    logic [SEL_W-1:0] sel_eff;

`ifdef MUX_TREE_SCAN_EN
    logic [SEL_W-1:0] scan_cnt;

    // Counts accepted samples while scanning; NUM_IN is a power of two, so the
    // natural SEL_W-bit wrap gives NUM_IN-1 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
        end else if (scan_en && in_valid && in_ready) begin
            scan_cnt <= scan_cnt + SEL_W'(1);
        end
    end

    assign sel_eff = scan_en ? scan_cnt : sel;
`else
    assign sel_eff = sel;
`endif

    // Each level keeps its own handshake/data nets; ready ripples back from
    // out_ready through every level so a full pipe still moves each cycle.
    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int OUT_W = width(NUM_IN, DATA_W, k);

        logic               v_in;
        logic               r_in;
        logic [SEL_W-1:0]   s_in;
        logic [2*OUT_W-1:0] d_in;
        logic               v_out;
        logic               r_out;
        logic [SEL_W-1:0]   s_out;
        logic [OUT_W-1:0]   d_out;

        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign s_in = sel_eff;
            assign d_in = in_data;
        end else begin : g_tail
            assign v_in = g_lvl[k-1].v_out;
            assign s_in = g_lvl[k-1].s_out;
            assign d_in = g_lvl[k-1].d_out;
        end

        if (k == SEL_W - 1) begin : g_last
            assign r_out = out_ready;
        end else begin : g_mid
            assign r_out = g_lvl[k+1].r_in;
        end

        mux_tree_stage #(
            .IN_WORDS (NUM_IN >> k),
            .DATA_W   (DATA_W),
            .SEL_W    (SEL_W),
            .LEVEL    (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (v_in),
            .in_ready  (r_in),
            .in_data   (d_in),
            .in_sel    (s_in),
            .out_valid (v_out),
            .out_ready (r_out),
            .out_data  (d_out),
            .out_sel   (s_out)
        );
    end

    assign in_ready  = g_lvl[0].r_in;
    assign out_valid = g_lvl[SEL_W-1].v_out;
    assign out_data  = g_lvl[SEL_W-1].d_out;
    assign out_sel   = g_lvl[SEL_W-1].s_out;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Testbench for mux_tree_pipe: a 16:1 x 1-bit instance driven through a
// scoreboard, plus a 4:1 x 8-bit instance checked directly.
module tb_mux_tree_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // 16:1, 1-bit instance
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] in_data   = '0;
    logic [3:0]  sel       = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [0:0]  out_data;
    logic [3:0]  out_sel;
`ifdef MUX_TREE_SCAN_EN
    logic        scan_en   = 1'b0;
`endif

    // 4:1, 8-bit instance
    logic        v4_in_valid  = 1'b0;
    logic        v4_in_ready;
    logic [31:0] v4_in_data   = '0;
    logic [1:0]  v4_sel       = '0;
    logic        v4_out_valid;
    logic        v4_out_ready = 1'b1;
    logic [7:0]  v4_out_data;
    logic [1:0]  v4_out_sel;

    mux_tree_pipe #(.NUM_IN(16), .DATA_W(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef MUX_TREE_SCAN_EN
        ,
        .scan_en   (scan_en)
`endif
    );

    mux_tree_pipe #(.NUM_IN(4), .DATA_W(8)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4_in_valid),
        .in_ready  (v4_in_ready),
        .in_data   (v4_in_data),
        .sel       (v4_sel),
        .out_valid (v4_out_valid),
        .out_ready (v4_out_ready),
        .out_data  (v4_out_data),
        .out_sel   (v4_out_sel)
`ifdef MUX_TREE_SCAN_EN
        ,
        .scan_en   (1'b0)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard entry: expected result plus the cycle the input was accepted.
    typedef struct {
        logic [0:0] data;
        logic [3:0] sel;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    bit   chk_lat   = 1'b0;
    int   popped    = 0;
    bit   stall_prev = 1'b0;
    logic [0:0] held_d;
    logic [3:0] held_s;
    logic [3:0] scan_model = '0;

    always @(posedge clk) cyc++;

    // Monitor: samples at the falling edge, between driving and the active edge.
    always @(negedge clk) begin
        exp_t       e;
        exp_t       got_e;
        logic [3:0] eff_sel;
        if (!rst_n) begin
            stall_prev = 1'b0;
            scan_model = '0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(held_d));
                check("hold_sel", 32'(out_sel), 32'(held_s));
            end
            stall_prev = out_valid && !out_ready;
            held_d     = out_data;
            held_s     = out_sel;

            eff_sel = sel;
`ifdef MUX_TREE_SCAN_EN
            if (scan_en) eff_sel = scan_model;
`endif
            if (in_valid && in_ready) begin
                e.sel  = eff_sel;
                e.data = in_data[eff_sel];
                e.cyc  = cyc;
                sb.push_back(e);
`ifdef MUX_TREE_SCAN_EN
                if (scan_en) scan_model = scan_model + 4'd1;
`endif
            end

            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    got_e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(got_e.data));
                    check("out_sel", 32'(out_sel), 32'(got_e.sel));
                    if (chk_lat) check("latency", 32'(cyc - got_e.cyc), 32'd4);
                    popped++;
                end
            end
        end
    end

    // Present one sample and hold it until accepted; entered and left at posedge+1.
    task automatic send(input logic [3:0] s);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        sel      = s;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 64);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         pat [5];
        logic [7:0] bytes4 [4];
        int         sels4 [4];
        pat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bytes4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        sels4  = '{2, 0, 3, 1};

        // Reset state
        #1 rst_n = 1'b0;
        #11;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_v4_out_valid", 32'(v4_out_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: back-to-back sweep of all channels, no backpressure
        in_data = 16'hAAAA;
        chk_lat = 1'b1;
        popped  = 0;
        for (int s = 0; s < 16; s++) send(4'(s));
        wait_drain("t1_drain");
        check("t1_count", 32'(popped), 32'd16);

        // 2: same stream with out_ready low for five cycles mid-stream
        chk_lat = 1'b0;
        popped  = 0;
        fork
            begin
                for (int s = 0; s < 16; s++) send(4'(s));
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("t2_in_ready_full", 32'(in_ready), 32'd0);
                check("t2_out_valid_stall", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("t2_drain");
        check("t2_count", 32'(popped), 32'd16);

        // 3: reset with samples in flight
        popped = 0;
        send(4'd1);
        send(4'd2);
        send(4'd3);
        @(posedge clk);
        #3;
        check("t3_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t3_rst_valid", 32'(out_valid), 32'd0);
        check("t3_rst_data", 32'(out_data), 32'd0);
        check("t3_rst_sel", 32'(out_sel), 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t3_quiet", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        send(4'd7);
        wait_drain("t3_drain");
        check("t3_count", 32'(popped), 32'd1);

        // 6: in_valid pattern 1,0,1,1,0 with sel=5; out_valid follows 4 cycles later
        popped  = 0;
        in_data = 16'h0020;
        sel     = 4'd5;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 5) ? pat[i] : 1'b0;
            @(negedge clk);
            if (i >= 4) check("t6_valid_pattern", 32'(out_valid), 32'(pat[i-4]));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_drain("t6_drain");
        check("t6_count", 32'(popped), 32'd3);

        // 4: NUM_IN=4, DATA_W=8, latency 2
        v4_in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int i = 0; i < 4; i++) begin
            v4_in_valid = 1'b1;
            v4_sel      = 2'(sels4[i]);
            @(negedge clk);
            check("t4_in_ready", 32'(v4_in_ready), 32'd1);
            @(posedge clk);
            #1 v4_in_valid = 1'b0;
            @(negedge clk);
            check("t4_valid_early", 32'(v4_out_valid), 32'd0);
            @(negedge clk);
            check("t4_valid", 32'(v4_out_valid), 32'd1);
            check("t4_data", 32'(v4_out_data), 32'(bytes4[sels4[i]]));
            check("t4_sel", 32'(v4_out_sel), 32'(sels4[i]));
            @(posedge clk);
            #1;
        end

`ifdef MUX_TREE_SCAN_EN
        // 5: scan mode, sel port ignored, counter wraps after 15
        popped  = 0;
        chk_lat = 1'b1;
        in_data = 16'h0001;
        scan_en = 1'b1;
        for (int i = 0; i < 20; i++) send(4'hF);
        scan_en = 1'b0;
        wait_drain("t5_drain");
        check("t5_count", 32'(popped), 32'd20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
